// File: rtl/usb_frame_parser.sv
// USB endpoint frame parser: SOF, type byte, little-endian length, payload and optional
// XOR checksum, with inter-byte timeout and error reporting.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an accepted SOF byte, other bytes ignored
// ST_TYPE  | next accepted byte is the frame type, seeds the checksum
// ST_LEN   | collecting LEN_BYTES length bytes, LSB first
// ST_PLD   | forwarding payload bytes until the length is reached
// ST_CHK   | comparing the trailing checksum byte against the accumulator

module usb_frame_parser #(
   parameter logic [3:0] EP_A      = 4'd1,
   parameter logic [3:0] EP_B      = 4'd2,
   parameter logic [7:0] SOF       = 8'h02,
   parameter int         LEN_BYTES = 4,
   parameter int         MAX_LEN   = 65536,
   parameter bit         CHK_EN    = 1'b1,
   parameter int         TIMEOUT   = 4096
) (
   input  logic                   i_usb_user_clk,
   input  logic                   i_rst,
   input  logic [3:0]             i_endpt_sel,
   input  logic                   i_usb_rxact,
   input  logic                   i_usb_rxval,
   input  logic [7:0]             i_usb_rxdat,
   input  logic                   i_os_type,
   output logic [7:0]             o_type,
   output logic [8*LEN_BYTES-1:0] o_len,
   output logic                   o_hdr_vld,
   output logic [7:0]             o_pld_dat,
   output logic                   o_pld_vld,
   output logic                   o_pld_last,
   output logic                   o_frm_ok,
   output logic                   o_frm_err,
   output logic [1:0]             o_err_code,
   output logic [15:0]            o_err_cnt
);

   localparam int          LEN_W     = 8 * LEN_BYTES;
   localparam int          TMO_W     = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
   localparam logic [32:0] MAX_LEN_W = 33'(MAX_LEN);
   localparam logic [1:0]  LEN_LAST  = 2'(LEN_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TYPE,
      ST_LEN,
      ST_PLD,
      ST_CHK
   } state_t;

   state_t            state, state_nxt;

   logic              s1_act, s1_val, s2_act, s2_val;
   logic [3:0]        s1_ep, s2_ep;
   logic [7:0]        s1_dat, s2_dat;
   logic              accept;

   logic [7:0]        acc, acc_nxt;
   logic [31:0]       len_acc, len_acc_nxt, len_full;
   logic [1:0]        len_idx, len_idx_nxt;
   logic [31:0]       len_tot, len_tot_nxt;
   logic [31:0]       pld_cnt, pld_cnt_nxt, pld_cnt_inc;
   logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
   logic              tmo_hit;
   logic              too_big;

   logic [7:0]        type_nxt, pld_dat_nxt;
   logic [LEN_W-1:0]  len_out_nxt;
   logic              hdr_nxt, pld_vld_nxt, pld_last_nxt, ok_nxt, err_nxt;
   logic [1:0]        err_code_nxt, err_val;
   logic [15:0]       err_cnt_nxt;
   logic              err_set;

   // two-stage input pipeline; the FSM only ever sees stage 2
   always_ff @(posedge i_usb_user_clk) begin
      if (i_rst) begin
         s1_act <= 1'b0;
         s1_val <= 1'b0;
         s1_ep  <= '0;
         s1_dat <= '0;
         s2_act <= 1'b0;
         s2_val <= 1'b0;
         s2_ep  <= '0;
         s2_dat <= '0;
      end else begin
         s1_act <= i_usb_rxact;
         s1_val <= i_usb_rxval;
         s1_ep  <= i_endpt_sel;
         s1_dat <= i_usb_rxdat;
         s2_act <= s1_act;
         s2_val <= s1_val;
         s2_ep  <= s1_ep;
         s2_dat <= s1_dat;
      end
   end

   assign accept      = s2_act && s2_val && (s2_ep == (i_os_type ? EP_B : EP_A));
   assign pld_cnt_inc = pld_cnt + 32'd1;
   assign too_big     = {1'b0, len_full} > MAX_LEN_W;

   always_comb begin
      len_full = len_acc;
      len_full[{len_idx, 3'b000} +: 8] = s2_dat;
   end

   always_ff @(posedge i_usb_user_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         acc        <= '0;
         len_acc    <= '0;
         len_idx    <= '0;
         len_tot    <= '0;
         pld_cnt    <= '0;
         tmo_cnt    <= '0;
         o_type     <= '0;
         o_len      <= '0;
         o_hdr_vld  <= 1'b0;
         o_pld_dat  <= '0;
         o_pld_vld  <= 1'b0;
         o_pld_last <= 1'b0;
         o_frm_ok   <= 1'b0;
         o_frm_err  <= 1'b0;
         o_err_code <= '0;
         o_err_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         len_acc    <= len_acc_nxt;
         len_idx    <= len_idx_nxt;
         len_tot    <= len_tot_nxt;
         pld_cnt    <= pld_cnt_nxt;
         tmo_cnt    <= tmo_nxt;
         o_type     <= type_nxt;
         o_len      <= len_out_nxt;
         o_hdr_vld  <= hdr_nxt;
         o_pld_dat  <= pld_dat_nxt;
         o_pld_vld  <= pld_vld_nxt;
         o_pld_last <= pld_last_nxt;
         o_frm_ok   <= ok_nxt;
         o_frm_err  <= err_nxt;
         o_err_code <= err_code_nxt;
         o_err_cnt  <= err_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      len_acc_nxt  = len_acc;
      len_idx_nxt  = len_idx;
      len_tot_nxt  = len_tot;
      pld_cnt_nxt  = pld_cnt;
      type_nxt     = o_type;
      len_out_nxt  = o_len;
      pld_dat_nxt  = o_pld_dat;
      hdr_nxt      = 1'b0;
      pld_vld_nxt  = 1'b0;
      pld_last_nxt = 1'b0;
      ok_nxt       = 1'b0;
      err_nxt      = 1'b0;
      err_code_nxt = o_err_code;
      err_cnt_nxt  = o_err_cnt;
      err_set      = 1'b0;
      err_val      = 2'd0;
      tmo_hit      = 1'b0;

      // down-counter reloaded by every accepted byte; a byte in the expiry cycle wins
      if (state == ST_IDLE || accept) begin
         tmo_nxt = TMO_LOAD;
      end else if (tmo_cnt == '0) begin
         tmo_nxt = tmo_cnt;
         tmo_hit = 1'b1;
      end else begin
         tmo_nxt = tmo_cnt - 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (accept && s2_dat == SOF) state_nxt = ST_TYPE;
         end
         ST_TYPE: begin
            if (accept) begin
               type_nxt    = s2_dat;
               acc_nxt     = s2_dat;
               len_acc_nxt = '0;
               len_idx_nxt = '0;
               state_nxt   = ST_LEN;
            end
         end
         ST_LEN: begin
            if (accept) begin
               acc_nxt     = acc ^ s2_dat;
               len_acc_nxt = len_full;
               if (len_idx == LEN_LAST) begin
                  if (too_big) begin
                     err_set   = 1'b1;
                     err_val   = 2'd1;
                     state_nxt = ST_IDLE;
                  end else begin
                     len_out_nxt = len_full[LEN_W-1:0];
                     len_tot_nxt = len_full;
                     pld_cnt_nxt = '0;
                     hdr_nxt     = 1'b1;
                     if (len_full != '0) begin
                        state_nxt = ST_PLD;
                     end else if (CHK_EN) begin
                        state_nxt = ST_CHK;
                     end else begin
                        ok_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                     end
                  end
               end else begin
                  len_idx_nxt = len_idx + 2'd1;
               end
            end
         end
         ST_PLD: begin
            if (accept) begin
               acc_nxt     = acc ^ s2_dat;
               pld_dat_nxt = s2_dat;
               pld_vld_nxt = 1'b1;
               pld_cnt_nxt = pld_cnt_inc;
               if (pld_cnt_inc == len_tot) begin
                  pld_last_nxt = 1'b1;
                  if (CHK_EN) begin
                     state_nxt = ST_CHK;
                  end else begin
                     ok_nxt    = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end
            end
         end
         ST_CHK: begin
            if (accept) begin
               if (s2_dat == acc) begin
                  ok_nxt = 1'b1;
               end else begin
                  err_set = 1'b1;
                  err_val = 2'd3;
               end
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (tmo_hit) begin
         err_set   = 1'b1;
         err_val   = 2'd2;
         state_nxt = ST_IDLE;
      end

      if (err_set) begin
         err_nxt      = 1'b1;
         err_code_nxt = err_val;
         if (o_err_cnt != 16'hFFFF) err_cnt_nxt = o_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_usb_frame_parser.sv
// Scoreboard bench for usb_frame_parser: each driven byte pushes the output event it
// should cause three cycles later; a negedge monitor pops and compares.

module tb_usb_frame_parser;

   localparam int         TMO   = 4096;
   localparam logic [7:0] SOF_V = 8'h02;
   localparam int         K_HDR = 0;
   localparam int         K_PLD = 1;
   localparam int         K_OK  = 2;
   localparam int         K_ERR = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  endpt = '0;
   logic        rxact = 1'b0;
   logic        rxval = 1'b0;
   logic [7:0]  rxdat = '0;
   logic        os_type = 1'b0;

   logic [7:0]  o_type;
   logic [31:0] o_len;
   logic        o_hdr_vld;
   logic [7:0]  o_pld_dat;
   logic        o_pld_vld;
   logic        o_pld_last;
   logic        o_frm_ok;
   logic        o_frm_err;
   logic [1:0]  o_err_code;
   logic [15:0] o_err_cnt;

   usb_frame_parser dut (
      .i_usb_user_clk (clk),
      .i_rst          (rst),
      .i_endpt_sel    (endpt),
      .i_usb_rxact    (rxact),
      .i_usb_rxval    (rxval),
      .i_usb_rxdat    (rxdat),
      .i_os_type      (os_type),
      .o_type         (o_type),
      .o_len          (o_len),
      .o_hdr_vld      (o_hdr_vld),
      .o_pld_dat      (o_pld_dat),
      .o_pld_vld      (o_pld_vld),
      .o_pld_last     (o_pld_last),
      .o_frm_ok       (o_frm_ok),
      .o_frm_err      (o_frm_err),
      .o_err_code     (o_err_code),
      .o_err_cnt      (o_err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int ecnt    = 0;
   int npulse;

   typedef struct {
      int          cyc;
      int          kind;
      logic [7:0]  dat;
      logic        last;
      logic [1:0]  code;
      logic [15:0] cnt;
      logic [7:0]  typ;
      logic [31:0] len;
   } ev_t;

   ev_t         exp_q[$];
   logic [7:0]  pl[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int k, input logic [7:0] d, input logic l,
                          input logic [1:0] code, input logic [7:0] typ, input logic [31:0] len);
      ev_t e;
      if (k == K_ERR && ecnt < 16'hFFFF) ecnt++;
      e.cyc  = c;
      e.kind = k;
      e.dat  = d;
      e.last = l;
      e.code = code;
      e.cnt  = 16'(ecnt);
      e.typ  = typ;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int k);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", k, 32'hFF);
         return;
      end
      e = exp_q.pop_front();
      chk("ev_kind", k, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      case (k)
         K_HDR: begin
            chk("hdr_type", o_type, e.typ);
            chk("hdr_len", o_len, e.len);
         end
         K_PLD: begin
            chk("pld_dat", o_pld_dat, e.dat);
            chk("pld_last", o_pld_last, e.last);
         end
         K_ERR: begin
            chk("err_code", o_err_code, e.code);
            chk("err_cnt", o_err_cnt, e.cnt);
         end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         npulse = int'(o_hdr_vld) + int'(o_pld_vld) + int'(o_frm_ok) + int'(o_frm_err);
         if (npulse != 0) chk("pulse_exclusive", npulse, 1);
         if (o_hdr_vld) pop_check(K_HDR);
         if (o_pld_vld) pop_check(K_PLD);
         if (o_frm_ok)  pop_check(K_OK);
         if (o_frm_err) pop_check(K_ERR);
      end
   end

   task automatic send_byte(input logic [3:0] ep, input logic [7:0] d, output int t);
      @(posedge clk);
      #1;
      rxact = 1'b1;
      rxval = 1'b1;
      endpt = ep;
      rxdat = d;
      t     = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rxact = 1'b0;
         rxval = 1'b0;
      end
   endtask

   // bad=1 corrupts the checksum byte; expect_ev=0 means the parser must ignore the frame
   task automatic send_frame(input logic [3:0] ep, input logic [7:0] typ, input logic [31:0] len,
                             input logic [7:0] p[$], input bit bad, input bit expect_ev);
      int         t;
      logic [7:0] acc;
      logic [7:0] b;
      send_byte(ep, SOF_V, t);
      send_byte(ep, typ, t);
      acc = typ;
      for (int i = 0; i < 4; i++) begin
         b = len[8*i +: 8];
         send_byte(ep, b, t);
         acc ^= b;
      end
      if (len > 32'd65536) begin
         if (expect_ev) push_ev(t + 3, K_ERR, 8'h0, 1'b0, 2'd1, 8'h0, 32'h0);
      end else begin
         if (expect_ev) push_ev(t + 3, K_HDR, 8'h0, 1'b0, 2'd0, typ, len);
         for (int i = 0; i < p.size(); i++) begin
            send_byte(ep, p[i], t);
            acc ^= p[i];
            if (expect_ev) push_ev(t + 3, K_PLD, p[i], (i == p.size() - 1), 2'd0, 8'h0, 32'h0);
         end
         send_byte(ep, bad ? (acc ^ 8'h01) : acc, t);
         if (expect_ev) begin
            if (bad) push_ev(t + 3, K_ERR, 8'h0, 1'b0, 2'd3, 8'h0, 32'h0);
            else     push_ev(t + 3, K_OK,  8'h0, 1'b0, 2'd0, 8'h0, 32'h0);
         end
      end
      idle(6);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, t2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_type", o_type, 0);
      chk("rst_len", o_len, 0);
      chk("rst_pld_dat", o_pld_dat, 0);
      chk("rst_err_code", o_err_code, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
      chk("rst_pulses", {o_hdr_vld, o_pld_vld, o_pld_last, o_frm_ok, o_frm_err}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(3);

      // clean frame, correct XOR checksum
      pl = {8'hAA, 8'hBB, 8'hCC};
      send_frame(4'd1, 8'h05, 32'd3, pl, 1'b0, 1'b1);
      // same frame with a corrupted checksum
      send_frame(4'd1, 8'h05, 32'd3, pl, 1'b1, 1'b1);
      // length one above the maximum
      pl = {};
      send_frame(4'd1, 8'h05, 32'h0001_0001, pl, 1'b0, 1'b1);
      // stray non-SOF bytes in idle must be ignored
      send_byte(4'd1, 8'h55, t);
      send_byte(4'd1, 8'h66, t);
      idle(4);
      // SOF value used as type and payload data
      pl = {8'h02, 8'h02};
      send_frame(4'd1, 8'h02, 32'd2, pl, 1'b0, 1'b1);
      chk("err_code_held", o_err_code, 1);
      // zero-length frame goes straight to the checksum
      pl = {};
      send_frame(4'd1, 8'h09, 32'd0, pl, 1'b0, 1'b1);

      // inter-byte gap exactly at expiry, then a full stall
      send_byte(4'd1, SOF_V, t);
      send_byte(4'd1, 8'h07, t);
      send_byte(4'd1, 8'h03, t);
      send_byte(4'd1, 8'h00, t);
      send_byte(4'd1, 8'h00, t);
      send_byte(4'd1, 8'h00, t);
      push_ev(t + 3, K_HDR, 8'h0, 1'b0, 2'd0, 8'h07, 32'd3);
      send_byte(4'd1, 8'h11, t);
      push_ev(t + 3, K_PLD, 8'h11, 1'b0, 2'd0, 8'h0, 32'h0);
      idle(TMO - 1);
      send_byte(4'd1, 8'h22, t2);
      push_ev(t2 + 3, K_PLD, 8'h22, 1'b0, 2'd0, 8'h0, 32'h0);
      push_ev(t2 + 3 + TMO, K_ERR, 8'h0, 1'b0, 2'd2, 8'h0, 32'h0);
      idle(TMO + 50);
      chk("tmo_queue_drained", exp_q.size(), 0);

      // host type B: endpoint 1 ignored, endpoint 2 parsed
      @(posedge clk);
      #1 os_type = 1'b1;
      idle(3);
      pl = {8'h10, 8'h20};
      send_frame(4'd1, 8'h44, 32'd2, pl, 1'b0, 1'b0);
      send_frame(4'd2, 8'h44, 32'd2, pl, 1'b0, 1'b1);
      @(posedge clk);
      #1 os_type = 1'b0;
      idle(3);

      // reset in the middle of a payload
      send_byte(4'd1, SOF_V, t);
      send_byte(4'd1, 8'h33, t);
      send_byte(4'd1, 8'h04, t);
      send_byte(4'd1, 8'h00, t);
      send_byte(4'd1, 8'h00, t);
      send_byte(4'd1, 8'h00, t);
      push_ev(t + 3, K_HDR, 8'h0, 1'b0, 2'd0, 8'h33, 32'd4);
      send_byte(4'd1, 8'h77, t);
      push_ev(t + 3, K_PLD, 8'h77, 1'b0, 2'd0, 8'h0, 32'h0);
      idle(5);
      chk("pre_rst_queue", exp_q.size(), 0);
      rst  = 1'b1;
      ecnt = 0;
      idle(2);
      @(negedge clk);
      chk("midrst_err_cnt", o_err_cnt, 0);
      chk("midrst_err_code", o_err_code, 0);
      chk("midrst_type", o_type, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(3);
      pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame(4'd1, 8'h3C, 32'd4, pl, 1'b0, 1'b1);
      idle(10);
      chk("final_err_cnt", o_err_cnt, 0);
      chk("final_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
